// File: rtl/scan_sequencer.sv
// Scan sequencer: generates the 3-bit select code for a 3-to-8 one-hot decoder,
// stepping at a prescaled rate in up, down or ping-pong order.
module scan_sequencer #(
  parameter int PRESCALE = 4,
  parameter int PW       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic [2:0] sel,
  output logic       dir,
  output logic       step,
  output logic       wrap
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  localparam logic [PW-1:0] PC_LAST = PW'(PRESCALE - 1);

  mode_t         mode_e;
  logic [PW-1:0] pc;
  logic          tick;
  logic [2:0]    sel_nx;
  logic          dir_nx;
  logic          wrap_nx;

  assign mode_e = mode_t'(mode);

  // Next select/direction if this edge turns out to be a tick.
  always_comb begin
    tick    = en && (mode_e != MODE_HOLD) && (pc == PC_LAST);
    sel_nx  = sel;
    dir_nx  = dir;
    wrap_nx = 1'b0;
    case (mode_e)
      MODE_UP: begin
        sel_nx  = sel + 3'd1;
        dir_nx  = 1'b1;
        wrap_nx = (sel == 3'd7);
      end
      MODE_DOWN: begin
        sel_nx  = sel - 3'd1;
        dir_nx  = 1'b0;
        wrap_nx = (sel == 3'd0);
      end
      MODE_PING: begin
        if (sel == 3'd7) begin
          sel_nx = 3'd6;
          dir_nx = 1'b0;
        end else if (sel == 3'd0) begin
          sel_nx = 3'd1;
          dir_nx = 1'b1;
        end else if (dir) begin
          sel_nx = sel + 3'd1;
        end else begin
          sel_nx = sel - 3'd1;
        end
        wrap_nx = (sel == 3'd1) && !dir;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel  <= 3'd0;
      dir  <= 1'b1;
      step <= 1'b0;
      wrap <= 1'b0;
      pc   <= '0;
    end else if (load) begin
      sel  <= load_val;
      dir  <= 1'b1;
      step <= 1'b0;
      wrap <= 1'b0;
      pc   <= '0;
    end else if (!en) begin
      step <= 1'b0;
      wrap <= 1'b0;
    end else if (mode_e == MODE_HOLD) begin
      pc   <= '0;
      step <= 1'b0;
      wrap <= 1'b0;
    end else if (tick) begin
      pc   <= '0;
      sel  <= sel_nx;
      dir  <= dir_nx;
      step <= 1'b1;
      wrap <= wrap_nx;
    end else begin
      pc   <= pc + PW'(1);
      step <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: three instances (PRESCALE 4, 1, 2) driven in parallel
// and compared every cycle against a behavioural scan model.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] sel_o  [3];
  logic       dir_o  [3];
  logic       step_o [3];
  logic       wrap_o [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int sel;
    int dir;
    int cnt;
    int step;
    int wrap;
  } mstate_t;

  mstate_t m [3];
  int      pre [3] = '{4, 1, 2};

  always #5 clk = ~clk;

  scan_sequencer #(.PRESCALE(4), .PW(16)) u_p4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .sel(sel_o[0]), .dir(dir_o[0]), .step(step_o[0]), .wrap(wrap_o[0]));

  scan_sequencer #(.PRESCALE(1), .PW(16)) u_p1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .sel(sel_o[1]), .dir(dir_o[1]), .step(step_o[1]), .wrap(wrap_o[1]));

  scan_sequencer #(.PRESCALE(2), .PW(16)) u_p2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .sel(sel_o[2]), .dir(dir_o[2]), .step(step_o[2]), .wrap(wrap_o[2]));

  // Ping-pong is treated as a walk around a 14-position ring: 0,1..7,6..1.
  function automatic int ringSel(int p);
    return (p <= 7) ? p : 14 - p;
  endfunction

  function automatic mstate_t modelNext(mstate_t s, int presc, bit rn, bit e,
                                        int md, bit ld, int lv);
    mstate_t n;
    int p;
    int np;
    n      = s;
    n.step = 0;
    n.wrap = 0;
    if (!rn) begin
      n.sel = 0; n.dir = 1; n.cnt = 0;
    end else if (ld) begin
      n.sel = lv; n.dir = 1; n.cnt = 0;
    end else if (!e) begin
      n.cnt = s.cnt;
    end else if (md == 3) begin
      n.cnt = 0;
    end else begin
      n.cnt = s.cnt + 1;
      if (n.cnt == presc) begin
        n.cnt  = 0;
        n.step = 1;
        if (md == 0) begin
          n.sel  = (s.sel + 1) % 8;
          n.dir  = 1;
          n.wrap = (n.sel == 0);
        end else if (md == 1) begin
          n.sel  = (s.sel + 7) % 8;
          n.dir  = 0;
          n.wrap = (n.sel == 7);
        end else begin
          if (s.sel == 0 || s.sel == 7) p = s.sel;
          else p = s.dir ? s.sel : 14 - s.sel;
          np     = (p + 1) % 14;
          n.sel  = ringSel(np);
          n.dir  = (np >= 1 && np <= 7) ? 1 : 0;
          n.wrap = (np == 0);
        end
      end
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance model, and compare all instances after the edge.
  task automatic applyStimulus(input bit rn, input bit e, input logic [1:0] md,
                               input bit ld, input logic [2:0] lv);
    rst_n    = rn;
    en       = e;
    mode     = md;
    load     = ld;
    load_val = lv;
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      m[i] = modelNext(m[i], pre[i], rn, e, int'(md), ld, int'(lv));
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("sel%0d", i),  int'(sel_o[i]),  m[i].sel);
      checkOutput($sformatf("dir%0d", i),  int'(dir_o[i]),  m[i].dir);
      checkOutput($sformatf("step%0d", i), int'(step_o[i]), m[i].step);
      checkOutput($sformatf("wrap%0d", i), int'(wrap_o[i]), m[i].wrap);
    end
  endtask

  initial begin
    logic [1:0] rmode;
    for (int i = 0; i < 3; i++) m[i] = '{0, 1, 0, 0, 0};
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; load = 1'b0; load_val = 3'd0;

    // Up scan from reset
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 3'd0);
    checkOutput("rst_sel", int'(sel_o[0]), 0);
    checkOutput("rst_dir", int'(dir_o[0]), 1);
    for (int c = 1; c <= 40; c++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 3'd0);
      if (c == 32) begin
        checkOutput("up_wrap32", int'(wrap_o[0]), 1);
        checkOutput("up_sel32",  int'(sel_o[0]),  0);
      end
    end

    // Load with en low, hold, then resume up
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 3'd5);
    checkOutput("load_sel", int'(sel_o[0]), 5);
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 3'd0);
    for (int c = 0; c < 4; c++)  applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 3'd0);
    checkOutput("hold_resume_sel", int'(sel_o[0]), 6);

    // Ping-pong from reset
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 3'd0);
    for (int c = 1; c <= 30; c++) begin
      applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 3'd0);
      if (c == 14 || c == 28) checkOutput("pp_wrap", int'(wrap_o[1]), 1);
      if (c == 8) checkOutput("pp_dir_fall", int'(dir_o[1]), 0);
    end

    // Down from reset
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'd0);
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 3'd0);
      if (c == 2) begin
        checkOutput("down_sel2",  int'(sel_o[2]),  7);
        checkOutput("down_wrap2", int'(wrap_o[2]), 1);
      end
    end

    // Reset beats load
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 3'd6);
    checkOutput("rst_over_load", int'(sel_o[2]), 0);

    // Randomized run
    rmode = 2'b00;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 9) == 0) rmode = 2'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 99) != 0),
                    ($urandom_range(0, 99) < 85),
                    rmode,
                    ($urandom_range(0, 99) < 3),
                    3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
